// File: rtl/vit_pkg.sv
// +--------------------------------------------------------------------------+
// | vit_pkg : shared types and defaults for the Viterbi input-side blocks    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package vit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } vit_state_e;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    localparam int VIT_N_OUT      = 2;
    localparam int VIT_FLUSH_SYMS = 20;

    // Counter width that still works for a range of a single value.
    function automatic int vit_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vit_frame_feeder.sv
// +--------------------------------------------------------------------------+
// | vit_frame_feeder : serialises coded words into symbols, appends flush    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module vit_frame_feeder
    import vit_pkg::*;
#(
    parameter int IN_W         = 16,
    parameter int N_OUT        = VIT_N_OUT,
    parameter int FLUSH_SYMS   = VIT_FLUSH_SYMS,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_i,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_last,
    output logic             sym_valid_o,
    output logic [N_OUT-1:0] sym_data_o,
    output logic             frame_done_o,
    output logic             busy_o
);

    localparam int W      = IN_W / N_OUT;
    localparam int CNT_W  = vit_cnt_w(W);
    localparam int FCNT_W = $clog2(FLUSH_SYMS + 1);
    localparam int ICNT_W = $clog2(IDLE_TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic [IN_W-1:0]   shreg_q, shreg_d;
    logic              mode_q, mode_d;
    logic              last_q, last_d;
    logic              armed_q, armed_d;
    logic              vld_q, vld_d;
    logic [N_OUT-1:0]  sym_q, sym_d;
    logic              done_q, done_d;

    logic last_sym;
    logic hs;

    assign last_sym = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(W - 1));
    assign s_ready  = (state_q == ST_IDLE) || (last_sym && !(mode_q && last_q));
    assign hs       = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        icnt_d  = icnt_q;
        shreg_d = shreg_q;
        mode_d  = mode_q;
        last_d  = last_q;
        armed_d = armed_q;
        vld_d   = vld_q;
        sym_d   = sym_q;
        done_d  = 1'b0;

        if (hs) begin
            // The first symbol leaves directly from s_data so words chain without bubbles.
            state_d = ST_SHIFT;
            cnt_d   = '0;
            shreg_d = s_data << N_OUT;
            vld_d   = 1'b1;
            sym_d   = s_data[IN_W-1 -: N_OUT];
            mode_d  = mode_i;
            last_d  = s_last;
            armed_d = 1'b1;
            icnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q && !mode_q && !s_valid) begin
                        if (icnt_q == ICNT_W'(IDLE_TIMEOUT - 1)) begin
                            state_d = ST_FLUSH;
                            fcnt_d  = FCNT_W'(1);
                            vld_d   = 1'b1;
                            sym_d   = '0;
                            armed_d = 1'b0;
                            icnt_d  = '0;
                        end else begin
                            icnt_d = icnt_q + ICNT_W'(1);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == CNT_W'(W - 1)) begin
                        if (mode_q && last_q) begin
                            state_d = ST_FLUSH;
                            fcnt_d  = FCNT_W'(1);
                            sym_d   = '0;
                            armed_d = 1'b0;
                            icnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                            vld_d   = 1'b0;
                            sym_d   = '0;
                            mode_d  = mode_i;
                        end
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        sym_d   = shreg_q[IN_W-1 -: N_OUT];
                        shreg_d = shreg_q << N_OUT;
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_q == FCNT_W'(FLUSH_SYMS)) begin
                        state_d = ST_IDLE;
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                        fcnt_d  = '0;
                        mode_d  = mode_i;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
                    sym_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            icnt_q  <= '0;
            shreg_q <= '0;
            mode_q  <= 1'b0;
            last_q  <= 1'b0;
            armed_q <= 1'b0;
            vld_q   <= 1'b0;
            sym_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            icnt_q  <= icnt_d;
            shreg_q <= shreg_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            armed_q <= armed_d;
            vld_q   <= vld_d;
            sym_q   <= sym_d;
            done_q  <= done_d;
        end
    end

    assign sym_valid_o  = vld_q;
    assign sym_data_o   = sym_q;
    assign frame_done_o = done_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

`default_nettype wire
